// File: rtl/approx_mul_ha_pipe_if.sv
// ----------------------------------------------------------------------------
// approx_mul_ha_pipe_if
// Streaming bundle for the approximate half-adder-array multiplier.
//   in_valid / in_ready : operand beat handshake (x, y, mode travel with it)
//   out_valid / out_ready : product handshake (p, p_mode travel with it)
// Modports:
//   master : operand source / product sink side
//   slave  : the multiplier itself
// ----------------------------------------------------------------------------
interface approx_mul_ha_pipe_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic                 mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;
    logic                 p_mode;

    modport master (
        output in_valid, x, y, mode, out_ready,
        input  in_ready, out_valid, p, p_mode
    );

    modport slave (
        input  in_valid, x, y, mode, out_ready,
        output in_ready, out_valid, p, p_mode
    );
endinterface

// File: rtl/approx_mul_ha_pipe.sv
// ----------------------------------------------------------------------------
// approx_mul_ha_pipe
// Three-stage elastic unsigned WIDTH x WIDTH multiplier built from WIDTH/2
// half-adder row pairs. Columns below APPROX_COLS may use an OR-sum with the
// carry dropped (mode = 1), which never overestimates the exact product.
//
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous reset, active-high
//   bus     : approx_mul_ha_pipe_if.slave (in_valid/in_ready/x/y/mode,
//             out_valid/out_ready/p/p_mode)
//   err_cnt : [CNT_W-1:0] saturating count of accepted products that differ
//             from the exact product (only with APPROX_MUL_ERR_CNT_EN)
//
// Optional feature macro: APPROX_MUL_ERR_CNT_EN
// ----------------------------------------------------------------------------
module approx_mul_ha_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 3,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    approx_mul_ha_pipe_if.slave bus
`ifdef APPROX_MUL_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]    err_cnt
`endif
);
    localparam int PAIRS = WIDTH / 2;
    localparam int PW    = 2 * WIDTH;

    if ((WIDTH < 4) || ((WIDTH % 2) != 0) || (CNT_W < 1) || (APPROX_COLS < 0)) begin : g_param_check
        $error("approx_mul_ha_pipe: WIDTH must be even and >= 4, CNT_W >= 1, APPROX_COLS >= 0");
    end

    // One half-adder cell: returns {carry, sum}. In approximate columns the
    // sum becomes a|b and the carry is discarded.
    function automatic logic [1:0] ha_cell(input logic a, input logic b, input logic approx);
        if (approx) begin
            return {1'b0, a | b};
        end
        return {a & b, a ^ b};
    endfunction

    // Control
    logic ld_p1, ld_p2, ld_p3;
    logic vld_p1_q, vld_p2_q, vld_p3_q;

    // Data
    logic [WIDTH-1:0]              x_p1_q, y_p1_q;
    logic                          mode_p1_q;
    logic [PAIRS-1:0][WIDTH-1:0]   t_d, cy_d;
    logic [PAIRS-1:0]              top_d;
    logic [PAIRS-1:0][WIDTH-1:0]   t_p2_q, cy_p2_q;
    logic [PAIRS-1:0]              top_p2_q;
    logic                          mode_p2_q;
    logic [PW-1:0]                 p_d;
    logic [PW-1:0]                 p_q;
    logic                          p_mode_q;

    // A stage loads when empty or when the stage after it moves this cycle.
    // in_ready never looks at in_valid.
    assign ld_p3 = !vld_p3_q || bus.out_ready;
    assign ld_p2 = !vld_p2_q || ld_p3;
    assign ld_p1 = !vld_p1_q || ld_p2;

    assign bus.in_ready  = ld_p1;
    assign bus.out_valid = vld_p3_q;
    assign bus.p         = p_q;
    assign bus.p_mode    = p_mode_q;

    // ---- S1 -> S2 boundary: half-adder rows from registered operands ----
    always_comb begin
        t_d   = '0;
        cy_d  = '0;
        top_d = '0;
        for (int k = 0; k < PAIRS; k++) begin
            t_d[k][0] = y_p1_q[0] & x_p1_q[2*k];
            for (int c = 1; c < WIDTH; c++) begin
                {cy_d[k][c], t_d[k][c]} = ha_cell(y_p1_q[c]   & x_p1_q[2*k],
                                                  y_p1_q[c-1] & x_p1_q[2*k+1],
                                                  mode_p1_q && ((2*k + c) < APPROX_COLS));
            end
            top_d[k] = y_p1_q[WIDTH-1] & x_p1_q[2*k+1];
        end
    end

    // ---- S2 -> S3 boundary: exact reduction of all row terms ----
    always_comb begin
        p_d = '0;
        for (int k = 0; k < PAIRS; k++) begin
            p_d = p_d + (PW'(t_p2_q[k])   << (2*k))
                      + (PW'(cy_p2_q[k])  << (2*k + 1))
                      + (PW'(top_p2_q[k]) << (2*k + WIDTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            p_q      <= '0;
            p_mode_q <= 1'b0;
        end else begin
            if (ld_p1) vld_p1_q <= bus.in_valid;
            if (ld_p2) vld_p2_q <= vld_p1_q;
            if (ld_p3) vld_p3_q <= vld_p2_q;
            if (ld_p3 && vld_p2_q) begin
                p_q      <= p_d;
                p_mode_q <= mode_p2_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld_p1) begin
            x_p1_q    <= bus.x;
            y_p1_q    <= bus.y;
            mode_p1_q <= bus.mode;
        end
        if (ld_p2) begin
            t_p2_q    <= t_d;
            cy_p2_q   <= cy_d;
            top_p2_q  <= top_d;
            mode_p2_q <= mode_p1_q;
        end
    end

`ifdef APPROX_MUL_ERR_CNT_EN
    // Exact shadow product travels beside the row terms for comparison.
    logic [PW-1:0]    exact_p2_q, exact_p3_q;
    logic [CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (ld_p2) exact_p2_q <= PW'(x_p1_q) * PW'(y_p1_q);
        if (ld_p3 && vld_p2_q) exact_p3_q <= exact_p2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (vld_p3_q && bus.out_ready && (p_q != exact_p3_q) && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_approx_mul_ha_pipe.sv
// ----------------------------------------------------------------------------
// tb_approx_mul_ha_pipe
// Directed + randomized bench for approx_mul_ha_pipe with a scoreboard fed by
// an arithmetic reference: the approximate product is the exact product less
// 2^q for every approximated column q where both row inputs are 1 (that is the
// value an OR-sum loses compared with a true two-bit add).
// ----------------------------------------------------------------------------
module tb_approx_mul_ha_pipe;
    localparam int W  = 8;
    localparam int AC = 3;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    approx_mul_ha_pipe_if #(.WIDTH(W)) bus();
`ifdef APPROX_MUL_ERR_CNT_EN
    logic [CW-1:0] err_cnt;
`endif

    approx_mul_ha_pipe #(
        .WIDTH(W),
        .APPROX_COLS(AC),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef APPROX_MUL_ERR_CNT_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [2*W:0] sb[$];
    logic [2*W:0] sb_e;
    logic         stall_prev = 1'b0;
    logic [2*W-1:0] p_prev;
    logic         m_prev;
    int run_len = 0;
    int max_run = 0;
    int n_out   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        int unsigned e;
        e = 32'(a) * 32'(b);
        if (m) begin
            for (int k = 0; k < W/2; k++) begin
                for (int c = 1; c < W; c++) begin
                    if ((2*k + c) < AC && a[2*k] && a[2*k+1] && b[c] && b[c-1])
                        e = e - (32'd1 << (2*k + c));
                end
            end
        end
        return e[2*W-1:0];
    endfunction

    // Scoreboard / protocol monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            stall_prev = 1'b0;
            run_len    = 0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 64'(bus.out_valid), 64'(1));
                check("hold_p", 64'(bus.p), 64'(p_prev));
                check("hold_mode", 64'(bus.p_mode), 64'(m_prev));
            end
            if (bus.out_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                check("sb_has_entry", 64'(sb.size() > 0), 64'(1));
                if (sb.size() > 0) begin
                    sb_e = sb.pop_front();
                    check("sb_p", 64'(bus.p), 64'(sb_e[2*W-1:0]));
                    check("sb_mode", 64'(bus.p_mode), 64'(sb_e[2*W]));
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back({bus.mode, ref_mul(bus.x, bus.y, bus.mode)});
            stall_prev = bus.out_valid && !bus.out_ready;
            p_prev     = bus.p;
            m_prev     = bus.p_mode;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic m);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.x        = xa;
        bus.y        = ya;
        bus.mode     = m;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("send_accepted", 64'(bus.in_ready), 64'(1));
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_expect(input string tag, input logic [2*W-1:0] ep, input logic em, output int lat);
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
        check({tag, "_p"}, 64'(bus.p), 64'(ep));
        check({tag, "_mode"}, 64'(bus.p_mode), 64'(em));
        cyc();
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while ((sb.size() != 0 || bus.out_valid) && n < 100) begin
            cyc();
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int acc;
        int out0;
        logic ir_last;
        logic [W-1:0] xr, yr;

        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_p", 64'(bus.p), 64'(0));
        check("rst_p_mode", 64'(bus.p_mode), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
`ifdef APPROX_MUL_ERR_CNT_EN
        check("rst_err_cnt", 64'(err_cnt), 64'(0));
`endif
        cyc();

        // Latency with max operands
        bus.out_ready = 1'b1;
        send(8'd255, 8'd255, 1'b0);
        wait_expect("max_exact", 16'd65025, 1'b0, lat);
        check("latency", 64'(lat), 64'(3));

        // Approximate vs exact on 3x3
        send(8'd3, 8'd3, 1'b1);
        wait_expect("approx_3x3", 16'd7, 1'b1, lat);
        send(8'd3, 8'd3, 1'b0);
        wait_expect("exact_3x3", 16'd9, 1'b0, lat);

        // Boundary operands in both modes, checked via the scoreboard
        send(8'd0, 8'd255, 1'b1);
        send(8'd255, 8'd0, 1'b0);
        send(8'd255, 8'd255, 1'b1);
        send(8'd1, 8'd1, 1'b1);
        send(8'd170, 8'd85, 1'b1);
        drain();

        // Back-to-back burst of 16 exact beats
        max_run = 0;
        out0    = n_out;
        for (int i = 0; i < 16; i++) begin
            xr = W'($urandom);
            yr = W'($urandom);
            send(xr, yr, 1'b0);
        end
        drain();
        check("burst_count", 64'(n_out - out0), 64'(16));
        check("burst_no_bubble", 64'(max_run), 64'(16));

        // Back-pressure: 5 stalled cycles while streaming
        acc           = 0;
        ir_last       = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.mode      = 1'b0;
        bus.x         = W'($urandom);
        bus.y         = W'($urandom);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ir_last = bus.in_ready;
            if (ir_last) acc++;
            cyc();
            if (ir_last) begin
                bus.x    = W'($urandom);
                bus.y    = W'($urandom);
                bus.mode = 1'($urandom);
            end
        end
        check("stall_accepts", 64'(acc), 64'(3));
        check("stall_in_ready", 64'(ir_last), 64'(0));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ir_last = bus.in_ready;
            cyc();
            if (ir_last) begin
                bus.x    = W'($urandom);
                bus.y    = W'($urandom);
                bus.mode = 1'($urandom);
            end
        end
        drain();

        // Random traffic with random back-pressure and modes
        for (int i = 0; i < 60; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.out_ready = ($urandom_range(3) != 0);
            bus.mode      = 1'($urandom);
            bus.x         = W'($urandom);
            bus.y         = W'($urandom);
            cyc();
        end
        drain();

`ifdef APPROX_MUL_ERR_CNT_EN
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        send(8'd3, 8'd3, 1'b1);
        send(8'd3, 8'd3, 1'b1);
        send(8'd255, 8'd255, 1'b0);
        drain();
        check("err_cnt_two", 64'(err_cnt), 64'(2));
`endif

        // Reset in the middle of a stream
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(W'($urandom), W'($urandom), 1'b1);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_p", 64'(bus.p), 64'(0));
`ifdef APPROX_MUL_ERR_CNT_EN
        check("midrst_err_cnt", 64'(err_cnt), 64'(0));
`endif
        cyc();
        @(negedge clk);
        check("midrst_no_output", 64'(bus.out_valid), 64'(0));
        check("midrst_in_ready", 64'(bus.in_ready), 64'(1));
        cyc();

        // Pipeline usable again after reset
        send(8'd12, 8'd13, 1'b0);
        wait_expect("post_rst", 16'd156, 1'b0, lat);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
